poc_host_driver: RTL

Parametrised host-side driver for the POC (parallel output controller) register interface. It accepts an arbitrary byte stream through a valid/ready port, buffers it in an internal FIFO, and delivers each message to the POC in polling or interrupt mode, selected per message. This replaces the fixed two-message test processor with a reusable driver that has programmable message content, per-message mode, read-settle timing, a ready/IRQ timeout and error reporting.

---
 rtl/poc_pkg.sv | 22 ++
 rtl/poc_tx_fifo.sv | 41 ++++
 rtl/poc_host_driver.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/poc_pkg.sv
// rtl/poc_pkg.sv - shared register map, mode encodings and driver state type for the POC host driver
package poc_pkg;

    localparam logic [2:0] SR0_ADDR  = 3'b000;
    localparam logic [2:0] DATA_ADDR = 3'b001;
    localparam logic [2:0] SR7_ADDR  = 3'b111;

    localparam logic MODE_POLL = 1'b0;
    localparam logic MODE_INT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SET_MODE,
        POLL_RD,
        INT_WAIT,
        SEND,
        SET_BUSY,
        DRAIN,
        FLUSH
    } poc_state_t;

endpackage

// File: rtl/poc_tx_fifo.sv
// rtl/poc_tx_fifo.sv - synchronous FIFO buffering {last, mode, data} entries ahead of the POC driver
module poc_tx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/poc_host_driver.sv
// rtl/poc_host_driver.sv - buffers a byte stream and delivers each message to the POC in polling or interrupt mode
module poc_host_driver
    import poc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SETTLE     = 3,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_mode,
    input  logic              irq,
    input  logic              reg_out,
    output logic              rw,
    output logic              reg_in,
    output logic [2:0]        addr,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              msg_done,
    output logic              err,
    input  logic              err_clr
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE + 1);

    poc_state_t        state, state_nxt;
    logic              mode_q;
    logic [SW-1:0]     settle_cnt;
    logic [TW-1:0]     to_cnt;
    logic [DATA_W+1:0] head;
    logic              full, empty, pop;
    logic              done_set, err_set, done_q, err_q;
    logic              settle_hit, to_hit, waiting, reading;

    poc_tx_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .wdata ({s_last, s_mode, s_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign reading    = (state == POLL_RD) || (state == DRAIN);
    assign waiting    = reading || (state == INT_WAIT);
    assign settle_hit = (settle_cnt == SW'(SETTLE));
    // Abort on the edge where the wait count would reach TIMEOUT.
    assign to_hit     = (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= MODE_POLL;
            settle_cnt <= '0;
            to_cnt     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            if (state == IDLE && !empty) mode_q <= head[DATA_W];
            settle_cnt <= (reading && state_nxt == state && !settle_hit) ? settle_cnt + 1'b1 : '0;
            to_cnt     <= (waiting && state_nxt == state) ? to_cnt + 1'b1 : '0;
            done_q     <= done_set;
            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE:     if (!empty) state_nxt = SET_MODE;
            SET_MODE: state_nxt = (mode_q == MODE_INT) ? INT_WAIT : POLL_RD;
            POLL_RD: begin
                if (settle_hit && reg_out && !empty) state_nxt = SEND;
                else if (to_hit) begin
                    err_set   = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            INT_WAIT: begin
                if (!irq && !empty) state_nxt = SEND;
                else if (to_hit) begin
                    err_set   = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            SEND:     state_nxt = SET_BUSY;
            SET_BUSY: begin
                pop = 1'b1;
                if (!head[DATA_W+1]) state_nxt = (mode_q == MODE_INT) ? INT_WAIT : POLL_RD;
                else if (mode_q == MODE_INT) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end else state_nxt = DRAIN;
            end
            DRAIN: begin
                if (settle_hit && reg_out) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end else if (to_hit) begin
                    // The last entry is already popped, so flushing would eat the next message.
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head[DATA_W+1]) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rw       = 1'b0;
        reg_in   = 1'b0;
        addr     = SR0_ADDR;
        data_out = '0;
        case (state)
            SET_MODE: begin
                rw     = 1'b1;
                reg_in = mode_q;
            end
            POLL_RD, DRAIN: addr = SR7_ADDR;
            SEND: begin
                rw       = 1'b1;
                addr     = DATA_ADDR;
                data_out = head[DATA_W-1:0];
            end
            SET_BUSY: begin
                rw   = 1'b1;
                addr = SR7_ADDR;
            end
            default: ;
        endcase
    end

    assign s_ready  = !full;
    assign busy     = (state != IDLE);
    assign msg_done = done_q;
    assign err      = err_q;

endmodule
